// File: rtl/unidade_pc.sv
// Program-counter stage feeding the instruction memory.
// Selects the next word address from sequential, branch, jump and
// jump-register controls. A four-state FSM handles start-up, IN waits,
// halt and out-of-range faults.
module unidade_pc #(
    parameter int                  PC_WIDTH         = 26,
    parameter logic [PC_WIDTH-1:0] ENDERECO_INICIAL = '0,
    parameter int                  MEM_SIZE         = 30
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                halt,
    input  logic                espera_in,
    input  logic                confirma_in,
    input  logic                desvio,
    input  logic                salto,
    input  logic                salto_reg,
    input  logic [15:0]         imediato,
    input  logic [25:0]         endereco_salto,
    input  logic [31:0]         registrador,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_mais_um,
    output logic [1:0]          estado,
    output logic                parado,
    output logic                erro
);

    typedef enum logic [1:0] {
        INICIO  = 2'b00,
        EXECUTA = 2'b01,
        ESPERA  = 2'b10,
        PARADO  = 2'b11
    } estado_t;

    // One extra bit so pc+1 at the top of the range is caught, not wrapped.
    localparam logic [PC_WIDTH:0] LIMITE = (PC_WIDTH+1)'(MEM_SIZE);

    estado_t             estado_q, estado_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                erro_q, erro_d;
    logic [PC_WIDTH:0]   incremento;
    logic [PC_WIDTH:0]   candidato;
    logic                avalia;

    assign incremento = {1'b0, pc_q} + {{PC_WIDTH{1'b0}}, 1'b1};

    // State, pc and fault flag registers; reset loads the start address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIO;
            pc_q     <= ENDERECO_INICIAL;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            erro_q   <= erro_d;
        end
    end

    // Next-state and next-pc selection with a shared range check on the candidate.
    always_comb begin
        estado_d  = estado_q;
        pc_d      = pc_q;
        erro_d    = erro_q;
        candidato = incremento;
        avalia    = 1'b0;
        unique case (estado_q)
            INICIO: begin
                estado_d = EXECUTA;
            end
            EXECUTA: begin
                if (halt) begin
                    estado_d = PARADO;
                end else if (espera_in && !confirma_in) begin
                    estado_d = ESPERA;
                end else begin
                    avalia = 1'b1;
                    if (espera_in)
                        candidato = incremento;
                    else if (salto_reg)
                        candidato = {1'b0, registrador[PC_WIDTH-1:0]};
                    else if (salto)
                        candidato = (PC_WIDTH+1)'(endereco_salto);
                    else if (desvio)
                        candidato = (PC_WIDTH+1)'(imediato);
                    else
                        candidato = incremento;
                end
            end
            ESPERA: begin
                if (confirma_in)
                    avalia = 1'b1;
            end
            PARADO: begin
                estado_d = PARADO;
            end
        endcase
        if (avalia) begin
            if (candidato >= LIMITE) begin
                estado_d = PARADO;
                erro_d   = 1'b1;
            end else begin
                pc_d     = candidato[PC_WIDTH-1:0];
                estado_d = EXECUTA;
            end
        end
    end

    // Outputs decoded straight from the registers.
    always_comb begin
        pc         = pc_q;
        pc_mais_um = incremento[PC_WIDTH-1:0];
        estado     = estado_q;
        parado     = (estado_q == PARADO);
        erro       = erro_q;
    end

endmodule

// File: doc/unidade_pc.md
Name: unidade_pc

Overview:
- Program-counter stage directly upstream of the instruction memory.
- Holds the current word address `pc` and drives it straight into the memory's `pc` input.
- Computes the next address from sequential, branch, jump and jump-register controls supplied by the control unit.
- Sequences start-up, IN-instruction waits, halt and out-of-range faults through a 4-state FSM.

Parameters:
- PC_WIDTH, 26: width of pc and of all address paths.
- ENDERECO_INICIAL, 0: word address loaded on reset.
- MEM_SIZE, 30: number of valid instruction words; any address >= MEM_SIZE is out of range.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- halt  input  1  current instruction is HALT.
- espera_in  input  1  current instruction is IN and needs user confirmation.
- confirma_in  input  1  user confirmation pulse, one cycle wide.
- desvio  input  1  conditional branch taken.
- salto  input  1  unconditional jump (J/JAL).
- salto_reg  input  1  jump register (JR).
- imediato  input  16  absolute branch target, zero-extended.
- endereco_salto  input  26  absolute jump target.
- registrador  input  32  JR source register; bits [PC_WIDTH-1:0] are used.
- pc  output  PC_WIDTH  current instruction address.
- pc_mais_um  output  PC_WIDTH  pc+1, combinational; used as the JAL link value.
- estado  output  2  FSM state: 00 INICIO, 01 EXECUTA, 10 ESPERA, 11 PARADO.
- parado  output  1  high when estado == PARADO.
- erro  output  1  sticky out-of-range fault flag.

Behaviour:
- Reset (async, immediate):
  - pc = ENDERECO_INICIAL, estado = INICIO, erro = 0, parado = 0.
  - pc_mais_um = ENDERECO_INICIAL+1.
- INICIO:
  - Lasts exactly one clock edge; pc held. This gives the instruction memory its load edge.
  - Next state EXECUTA unconditionally; all control inputs ignored.
- EXECUTA: each edge evaluates the controls in priority order.
  1. halt: go to PARADO, pc held.
  2. espera_in with confirma_in=1: pc = pc+1, stay in EXECUTA.
  3. espera_in with confirma_in=0: go to ESPERA, pc held.
  4. salto_reg: candidate = registrador[PC_WIDTH-1:0].
  5. salto: candidate = endereco_salto.
  6. desvio: candidate = {zeros, imediato}.
  7. Otherwise: candidate = pc+1.
- Range check on the candidate:
  - Compare in PC_WIDTH+1 bits, so pc+1 never wraps silently.
  - If candidate >= MEM_SIZE: go to PARADO, erro = 1, pc keeps its old value.
  - Otherwise pc = candidate, stay in EXECUTA.
- ESPERA:
  - pc held; halt, desvio, salto and salto_reg are ignored.
  - confirma_in=1: pc = pc+1 with the same range check, then EXECUTA (or PARADO with erro=1 on fault).
- PARADO:
  - Absorbing state; pc, erro and estado held until reset.
- Outputs:
  - parado is combinational from estado.
  - pc_mais_um is always pc+1, truncated to PC_WIDTH.
- Latency: a new pc is visible one clock after the edge that samples the control inputs; there is no bubble between consecutive instructions.
- Simultaneous events:
  - Priority list above resolves multiple asserted controls.
  - reset overrides everything, including mid-ESPERA and in PARADO.
  - confirma_in outside EXECUTA-with-espera_in and ESPERA has no effect.

Test Plan:
- Reset release, no controls asserted -> pc stays 0 for the first edge (INICIO), then counts 1,2,3; estado 00 -> 01.
- At pc=5 assert salto=1 with endereco_salto=20 and desvio=1 with imediato=7 -> next pc=20 (salto wins); then salto_reg=1 with registrador=0x0000000F -> pc=15.
- At pc=6 assert espera_in=1, confirma_in=0 -> estado=10, pc=6 held for 10 cycles with salto=1 ignored; pulse confirma_in -> pc=7, estado=01.
- At pc=19 assert halt=1 -> estado=11, parado=1, pc=19 frozen for 20 cycles despite salto/confirma_in activity.
- Sequential run to pc=29 -> next edge estado=11, erro=1, pc=29; jump to endereco_salto=30 from pc=3 -> erro=1, pc=3.
- Assert reset asynchronously mid-ESPERA and in PARADO with erro=1 -> pc=0, estado=00, erro=0 immediately, without waiting for a clock edge.
